// File: rtl/wallace_cpa_acc.sv
// Carry-propagate resolve of the Wallace carry-save product, TAPS-deep window accumulation,
// round-half-up / arithmetic shift / saturate, and a valid/ready result port.
module wallace_cpa_acc #(
    parameter int WIDTH_DATA = 16,
    parameter int TAPS       = 3,
    parameter int ACC_WIDTH  = 40,
    parameter int SHIFT      = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*WIDTH_DATA-1:0] sum_in,
    input  logic [2*WIDTH_DATA-1:0] cout_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic                    out_sat
);

    localparam int PW    = 2 * WIDTH_DATA;
    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
    localparam logic [ACC_WIDTH:0] RND_ONE = (ACC_WIDTH + 1)'(1);
    localparam logic [ACC_WIDTH:0] RND =
        (SHIFT > 0) ? (RND_ONE << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

    logic                        stall;
    logic                        accept;
    logic                        window_done;

    logic                        v1;
    logic [PW-1:0]               p1;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]            tap_cnt;

    logic signed [ACC_WIDTH-1:0] p1_ext;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH:0]   rnd_sum;
    logic signed [ACC_WIDTH:0]   r_shift;
    logic [ACC_WIDTH-OUT_WIDTH+1:0] r_upper;
    logic                        clip;
    logic [OUT_WIDTH-1:0]        sat_val;

    assign stall       = out_valid & ~out_ready;
    assign in_ready    = rst_n & ~stall;
    assign accept      = in_valid & in_ready;
    assign window_done = v1 & ~stall & (tap_cnt == LAST_TAP);

    // One extra bit of headroom so the rounding constant can never wrap the sum.
    assign p1_ext   = ACC_WIDTH'($signed(p1));
    assign acc_next = acc + p1_ext;
    assign rnd_sum  = $signed({acc_next[ACC_WIDTH-1], acc_next}) + $signed(RND);
    assign r_shift  = rnd_sum >>> SHIFT;

    // Fits in OUT_WIDTH only when every bit above the output sign bit matches it.
    assign r_upper = r_shift[ACC_WIDTH:OUT_WIDTH-1];
    assign clip    = ~((&r_upper) | ~(|r_upper));

    always_comb begin
        sat_val = r_shift[OUT_WIDTH-1:0];
        if (clip) begin
            sat_val = r_shift[ACC_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                         : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            p1 <= '0;
        end else if (!stall) begin
            v1 <= accept;
            if (accept) begin
                p1 <= sum_in + (cout_in << 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            tap_cnt <= '0;
        end else if (v1 && !stall) begin
            if (tap_cnt == LAST_TAP) begin
                acc     <= '0;
                tap_cnt <= '0;
            end else begin
                acc     <= acc_next;
                tap_cnt <= tap_cnt + CNT_W'(1);
            end
        end
    end

    // A completing window overwrites a result being handed off in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (window_done) begin
            out_valid <= 1'b1;
            out_data  <= sat_val;
            out_sat   <= clip;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
